// File: rtl/digit_entry.sv
// digit_entry: debounced hex keypad entry into an 8-digit shift display.
//
// Ports:
//   hz100    in   system clock, all state moves on the rising edge
//   reset    in   synchronous active-high reset
//   pb       in   16 hex keys, pb[k] enters digit k (asynchronous)
//   bksp     in   backspace key (asynchronous)
//   clr      in   clear key (asynchronous)
//   dp       in   decimal-point key (asynchronous)
//   digits   out  displayed nibbles, [0] rightmost
//   flt_pt   out  decimal-point enables, bit i belongs to digit i
//   ndigits  out  number of entered digits, 0..8
//   full     out  high when ndigits == 8
//   strobe   out  one-cycle pulse when a key action is performed
//   err      out  one-cycle pulse when an accepted key is rejected
//
// All 19 keys are synchronized together and treated as one key vector
// {dp, clr, bksp, pb}. A vector must stay identical for DEBOUNCE_CYCLES
// cycles before it is acted on, and it must be fully released before the
// next press is considered, so a held key never repeats.
module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 2
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic [15:0]     pb,
  input  logic            bksp,
  input  logic            clr,
  input  logic            dp,
  output logic [7:0][3:0] digits,
  output logic [7:0]      flt_pt,
  output logic [3:0]      ndigits,
  output logic            full,
  output logic            strobe,
  output logic            err
);

  localparam int KW       = 19;
  localparam int BKSP_BIT = 16;
  localparam int CLR_BIT  = 17;
  localparam int DP_BIT   = 18;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    ACCEPT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  // Position of the (single) set bit of a hex-key vector.
  function automatic logic [3:0] hex_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  logic [KW-1:0]   sync1_q;
  logic [KW-1:0]   sync2_q;
  logic [KW-1:0]   key_s;
  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [KW-1:0]   latch_q, latch_d;
  logic [7:0][3:0] digits_q, digits_d;
  logic [7:0]      flt_q, flt_d;
  logic [3:0]      nd_q, nd_d;
  logic            strobe_q, strobe_d;
  logic            err_q, err_d;
  logic            single_s;
  logic            ok_s;

  assign key_s = sync2_q;

  // Decide whether the latched key can be performed given the current count.
  // The latched vector and count are stable from the last DEBOUNCE cycle
  // through ACCEPT, so the same decision drives the pulses and the update.
  always_comb begin
    single_s = ((latch_q & (latch_q - 19'd1)) == 19'd0);
    ok_s     = 1'b0;
    if (!single_s) begin
      ok_s = 1'b0;
    end else if (|latch_q[15:0]) begin
      ok_s = (nd_q != 4'd8);
    end else if (latch_q[BKSP_BIT] || latch_q[DP_BIT]) begin
      ok_s = (nd_q != 4'd0);
    end else if (latch_q[CLR_BIT]) begin
      ok_s = 1'b1;
    end else begin
      ok_s = 1'b0;
    end
  end

  // Key FSM next state; strobe/err are registered on entry to ACCEPT so
  // they are high exactly during the ACCEPT cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_d  = latch_q;
    strobe_d = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_s != 19'd0) begin
          latch_d = key_s;
          cnt_d   = 8'd0;
          state_d = DEBOUNCE;
        end else begin
          state_d = IDLE;
        end
      end
      DEBOUNCE: begin
        if (key_s != latch_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ACCEPT;
          strobe_d = ok_s;
          err_d    = ~ok_s;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACCEPT: begin
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (key_s == 19'd0) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Display update, applied on the edge that ends ACCEPT.
  always_comb begin
    digits_d = digits_q;
    flt_d    = flt_q;
    nd_d     = nd_q;
    if ((state_q == ACCEPT) && ok_s) begin
      if (|latch_q[15:0]) begin
        digits_d = {digits_q[6:0], hex_index(latch_q[15:0])};
        flt_d    = {flt_q[6:0], 1'b0};
        nd_d     = nd_q + 4'd1;
      end else if (latch_q[BKSP_BIT]) begin
        digits_d = {4'h0, digits_q[7:1]};
        flt_d    = {1'b0, flt_q[7:1]};
        nd_d     = nd_q - 4'd1;
      end else if (latch_q[DP_BIT]) begin
        // A new point replaces any existing one.
        flt_d = 8'h01;
      end else begin
        digits_d = 32'h0;
        flt_d    = 8'h00;
        nd_d     = 4'd0;
      end
    end else begin
      digits_d = digits_q;
    end
  end

  // State, synchronizer and display registers.
  always_ff @(posedge hz100) begin
    if (reset) begin
      sync1_q  <= 19'd0;
      sync2_q  <= 19'd0;
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      latch_q  <= 19'd0;
      digits_q <= 32'h0;
      flt_q    <= 8'h00;
      nd_q     <= 4'd0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= {dp, clr, bksp, pb};
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      latch_q  <= latch_d;
      digits_q <= digits_d;
      flt_q    <= flt_d;
      nd_q     <= nd_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  assign digits  = digits_q;
  assign flt_pt  = flt_q;
  assign ndigits = nd_q;
  assign full    = (nd_q == 4'd8);
  assign strobe  = strobe_q;
  assign err     = err_q;

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 2, number of consecutive stable hz100 cycles before a key is accepted (legal range 1..255).
REQ-002 SHALL have port: hz100  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: pb  input  16  hex keys; pb[k] enters digit k (0x0..0xF); asynchronous, active-high.
REQ-005 SHALL have port: bksp  input  1  backspace key; asynchronous, active-high.
REQ-006 SHALL have port: clr  input  1  clear key; asynchronous, active-high.
REQ-007 SHALL have port: dp  input  1  decimal-point key; asynchronous, active-high.
REQ-008 SHALL have port: digits  output  [7:0][3:0]  displayed nibbles, [0] rightmost; feeds the seven-segment decoder.
REQ-009 SHALL have port: flt_pt  output  8  decimal-point enables, bit i for digit i; feeds the seven-segment decoder.
REQ-010 SHALL have port: ndigits  output  4  count of entered digits, 0..8.
REQ-011 SHALL have port: full  output  1  high when ndigits == 8.
REQ-012 SHALL have port: strobe  output  1  one-cycle pulse when a key action is performed.
REQ-013 SHALL have port: err  output  1  one-cycle pulse when an accepted key is rejected.

Function
REQ-014 SHALL pass all 19 key inputs through a 2-flop synchronizer; the "key vector" below is the 19-bit synchronized value.
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, ACCEPT, WAIT_RELEASE.
REQ-016 IDLE: key vector nonzero -> latch vector, clear counter, go to DEBOUNCE; otherwise remain in IDLE.
REQ-017 DEBOUNCE: key vector != latched vector -> IDLE; else if counter == DEBOUNCE_CYCLES-1 -> ACCEPT; else counter+1.
REQ-018 ACCEPT: lasts exactly one cycle; performs the action of REQ-020..REQ-024; then WAIT_RELEASE.
REQ-019 WAIT_RELEASE: remain until the key vector is all zero, then go to IDLE; no action while held (no auto-repeat).
REQ-020 Latched vector with more than one bit set: no register change, err=1, strobe=0.
REQ-021 Hex key k with ndigits<8: digits[i]<=digits[i-1] for i=7..1, digits[0]<=k; flt_pt<={flt_pt[6:0],1'b0}; ndigits+1; strobe=1. With ndigits==8: no change, err=1.
REQ-022 bksp with ndigits>0: digits[i]<=digits[i+1] for i=0..6, digits[7]<=0; flt_pt<={1'b0,flt_pt[7:1]}; ndigits-1; strobe=1. With ndigits==0: no change, err=1.
REQ-023 dp with ndigits>0: flt_pt<=8'h01, so at most one point exists; strobe=1. With ndigits==0: no change, err=1.
REQ-024 clr: digits<=0, flt_pt<=0, ndigits<=0, strobe=1; never errs.
REQ-025 strobe and err SHALL be asserted only during the ACCEPT cycle and never together; register updates SHALL be visible on the edge that ends ACCEPT.
REQ-026 Latency: an input asserted before edge 0 and held SHALL reach ACCEPT after edge 2+DEBOUNCE_CYCLES (default: after edge 4); its result SHALL be visible after edge 5.
REQ-027 full SHALL be a combinational decode of ndigits == 8.

Reset
REQ-028 reset high at a clock edge SHALL set: state=IDLE, synchronizers=0, counter=0, latched vector=0, digits=0, flt_pt=0, ndigits=0, strobe=0, err=0.
REQ-029 reset SHALL override every state including ACCEPT; no action from that cycle occurs.
REQ-030 A key still held after reset deasserts SHALL be treated as a new press and accepted after full debounce.

Verification
REQ-031 Press pb[3], then pb[10], then pb[5], releasing each -> digits[2:0]=3,A,5, ndigits=3, exactly three strobe pulses, each in the cycle after edge 4 of its press.
REQ-032 Pulse pb[7] for 1 cycle, then glitch high for DEBOUNCE_CYCLES-1 cycles -> no strobe, digits unchanged.
REQ-033 Enter 8 digits 1..8, then press pb[9] -> err pulse, digits={1,2,3,4,5,6,7,8}, full=1; then bksp -> digits[0]=7, digits[7]=0, ndigits=7.
REQ-034 On an empty display: press dp -> err; enter 4,2, press dp, then enter 7 -> digits[2:0]=4,2,7, flt_pt=8'h02.
REQ-035 Press pb[1] and pb[2] together -> err pulse, no change; press clr -> all zero, strobe; assert reset during DEBOUNCE of pb[6] while key held -> outputs zero, then 6 accepted after full debounce.
